// File: rtl/button_debouncer.sv
// Pushbutton debouncer with press/release strobes and auto-repeat.
//
// The raw active-low button is synchronised through two flops, then a five-state FSM
// requires the synchronised level to stay stable for DEBOUNCE_CYCLES before it accepts
// a press or a release. While a press is held, the first repeat strobe fires
// HOLD_CYCLES after the press strobe, and further strobes follow every REPEAT_CYCLES.
//
// Ports:
//   clk           - system clock; all state changes on its rising edge
//   rst           - synchronous active-high reset
//   btn_n         - raw pushbutton, asynchronous, active-low (0 = pressed)
//   level         - debounced button state, 1 = pressed (registered)
//   press_pulse   - one-cycle strobe when a press is accepted (registered)
//   release_pulse - one-cycle strobe when a release is accepted (registered)
//   repeat_pulse  - one-cycle strobe per auto-repeat event (registered)
//
// All three timing parameters must be >= 2 and < 2^32.

module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 120000,
  parameter int unsigned HOLD_CYCLES     = 6000000,
  parameter int unsigned REPEAT_CYCLES   = 1200000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  // Terminal counts: the single counter runs 0..N-1 in each timed state.
  localparam logic [31:0] DebLast  = 32'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] HoldLast = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0] RptLast  = 32'(REPEAT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StPressWait,
    StHeld,
    StRepeat,
    StReleaseWait
  } state_e;

  // ---------------------------------------------------------------------------
  // Input synchroniser. Both flops reset to 1 so the button reads as released.
  // ---------------------------------------------------------------------------
  logic sync1_q, sync2_q;
  logic pressed_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
    end
  end

  assign pressed_s = ~sync2_q;

  // ---------------------------------------------------------------------------
  // FSM state, counter and registered outputs.
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        level_q, level_d;
  logic        press_q, press_d;
  logic        release_q, release_d;
  logic        repeat_q, repeat_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and counter logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (pressed_s) begin
          state_d = StPressWait;
        end
      end

      StPressWait: begin
        if (!pressed_s) begin
          // Bounce during press qualification: drop back silently.
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == DebLast) begin
          state_d = StHeld;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      StHeld: begin
        if (!pressed_s) begin
          state_d = StReleaseWait;
          cnt_d   = '0;
        end else if (cnt_q == HoldLast) begin
          state_d = StRepeat;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      StRepeat: begin
        if (!pressed_s) begin
          state_d = StReleaseWait;
          cnt_d   = '0;
        end else if (cnt_q == RptLast) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      StReleaseWait: begin
        if (pressed_s) begin
          // Release bounce: still pressed, and the hold timer starts over.
          state_d = StHeld;
          cnt_d   = '0;
        end else if (cnt_q == DebLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: computes the values the output registers take at the next
  // edge, so each strobe lines up with the state transition that causes it.
  // ---------------------------------------------------------------------------
  always_comb begin
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;
    case (state_q)
      StIdle: begin
        level_d = 1'b0;
      end

      StPressWait: begin
        if (pressed_s && (cnt_q == DebLast)) begin
          level_d = 1'b1;
          press_d = 1'b1;
        end
      end

      StHeld: begin
        if (pressed_s && (cnt_q == HoldLast)) begin
          repeat_d = 1'b1;
        end
      end

      StRepeat: begin
        if (pressed_s && (cnt_q == RptLast)) begin
          repeat_d = 1'b1;
        end
      end

      StReleaseWait: begin
        if (!pressed_s && (cnt_q == DebLast)) begin
          level_d   = 1'b0;
          release_d = 1'b1;
        end
      end

      default: begin
        level_d = 1'b0;
      end
    endcase
  end

  assign level         = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign repeat_pulse  = repeat_q;

  // ---------------------------------------------------------------------------
  // Behavioural checks on the output contract.
  // ---------------------------------------------------------------------------
  a_pulses_exclusive: assert property (@(posedge clk) disable iff (rst)
    $onehot0({press_q, release_q, repeat_q}));

  a_press_one_cycle: assert property (@(posedge clk) disable iff (rst)
    press_q |=> !press_q);

  a_release_one_cycle: assert property (@(posedge clk) disable iff (rst)
    release_q |=> !release_q);

  a_press_with_level: assert property (@(posedge clk) disable iff (rst)
    press_q |-> level_q);

  a_release_with_level: assert property (@(posedge clk) disable iff (rst)
    release_q |-> !level_q);

  a_cnt_debounce_bound: assert property (@(posedge clk) disable iff (rst)
    (state_q == StPressWait || state_q == StReleaseWait) |-> (cnt_q <= DebLast));

  a_cnt_hold_bound: assert property (@(posedge clk) disable iff (rst)
    (state_q == StHeld) |-> (cnt_q <= HoldLast));

  a_cnt_repeat_bound: assert property (@(posedge clk) disable iff (rst)
    (state_q == StRepeat) |-> (cnt_q <= RptLast));

  a_cnt_idle_zero: assert property (@(posedge clk) disable iff (rst)
    (state_q == StIdle) |-> (cnt_q == '0));

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer with short timing parameters.
// Expected pulse events (kind + cycle) are queued when stimulus is applied and
// compared as the DUT emits pulses.

module tb_button_debouncer;

  localparam int unsigned Deb  = 4;
  localparam int unsigned Hold = 10;
  localparam int unsigned Rpt  = 3;

  localparam int KPress   = 1;
  localparam int KRelease = 2;
  localparam int KRepeat  = 3;

  logic clk;
  logic rst;
  logic btn_n;
  logic level;
  logic press_pulse;
  logic release_pulse;
  logic repeat_pulse;

  button_debouncer #(
    .DEBOUNCE_CYCLES(Deb),
    .HOLD_CYCLES    (Hold),
    .REPEAT_CYCLES  (Rpt)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .btn_n        (btn_n),
    .level        (level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .repeat_pulse (repeat_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising-edge count; only read on falling edges.
  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  ev_t sb_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_ev(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.cyc  = at;
    sb_q.push_back(e);
  endtask

  // Monitor: every emitted pulse must match the next queued expectation.
  int  mon_kind;
  ev_t mon_ev;
  always @(negedge clk) begin
    if (press_pulse || release_pulse || repeat_pulse) begin
      mon_kind = press_pulse ? KPress : (release_pulse ? KRelease : KRepeat);
      check("pulse_onehot", $countones({press_pulse, release_pulse, repeat_pulse}), 1);
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", mon_kind, 0);
      end else begin
        mon_ev = sb_q.pop_front();
        check("pulse_kind", mon_kind, mon_ev.kind);
        check("pulse_cycle", cyc, mon_ev.cyc);
        check("pulse_level", int'(level), (mon_kind == KRelease) ? 0 : 1);
      end
    end
  end

  int c, c2, b, q, r;

  initial begin
    rst   = 1'b1;
    btn_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_level", int'(level), 0);
    check("rst_press", int'(press_pulse), 0);
    check("rst_release", int'(release_pulse), 0);
    check("rst_repeat", int'(repeat_pulse), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_level", int'(level), 0);

    // Clean press, held long enough for seven repeats.
    c     = cyc;
    btn_n = 1'b0;
    push_ev(KPress, c + 7);
    for (int k = 0; k < 7; k++) push_ev(KRepeat, c + 7 + 10 + 3 * k);
    repeat (7) @(negedge clk);
    check("press_level", int'(level), 1);
    repeat (28) @(negedge clk);
    check("hold_level", int'(level), 1);

    // Release with a one-cycle bounce back to pressed.
    c2    = cyc;
    btn_n = 1'b1;
    push_ev(KRelease, c2 + 10);
    repeat (2) @(negedge clk);
    btn_n = 1'b0;
    @(negedge clk);
    btn_n = 1'b1;
    for (int i = 4; i <= 9; i++) begin
      @(negedge clk);
      check("rel_glitch_level", int'(level), 1);
    end
    @(negedge clk);
    check("released_level", int'(level), 0);
    repeat (5) @(negedge clk);

    // Press with a bounce: 3 low, 1 high, then held.
    b     = cyc;
    q     = b + 11;
    btn_n = 1'b0;
    push_ev(KPress, q);
    push_ev(KRepeat, q + 10);
    push_ev(KRepeat, q + 13);
    repeat (3) @(negedge clk);
    btn_n = 1'b1;
    @(negedge clk);
    btn_n = 1'b0;
    repeat (q + 14 - cyc) @(negedge clk);

    // Reset for one cycle while repeating, button still held.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_level", int'(level), 0);
    check("rst_mid_repeat", int'(repeat_pulse), 0);
    check("rst_mid_press", int'(press_pulse), 0);
    push_ev(KPress, cyc + 7);
    repeat (8) @(negedge clk);
    check("repress_level", int'(level), 1);

    // Clean release.
    r     = cyc;
    btn_n = 1'b1;
    push_ev(KRelease, r + 7);
    repeat (10) @(negedge clk);
    check("rerelease_level", int'(level), 0);

    // Short tap: three sampled lows produce nothing.
    btn_n = 1'b0;
    repeat (3) @(negedge clk);
    btn_n = 1'b1;
    repeat (20) @(negedge clk);
    check("tap_level", int'(level), 0);

    check("sb_drain", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 SHALL provide parameter DEBOUNCE_CYCLES, default 120000, stable-input cycles required to accept a press or release (10 ms at 12 MHz).
REQ-002 SHALL provide parameter HOLD_CYCLES, default 6000000, cycles of continuous accepted press before auto-repeat begins (0.5 s).
REQ-003 SHALL provide parameter REPEAT_CYCLES, default 1200000, cycles between auto-repeat pulses (0.1 s).
REQ-004 clk  input  1  12 MHz system clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 btn_n  input  1  raw pushbutton, asynchronous, active-low (0 = pressed).
REQ-007 level  output  1  debounced button state, 1 = pressed.
REQ-008 press_pulse  output  1  one-cycle strobe on accepted press.
REQ-009 release_pulse  output  1  one-cycle strobe on accepted release.
REQ-010 repeat_pulse  output  1  one-cycle strobe per auto-repeat event; drives the downstream counter's count-enable.

Function
REQ-011 btn_n SHALL pass through a two-flop synchronizer; pressed_s = inverted second-flop output; no other logic SHALL read btn_n.
REQ-012 SHALL use one 32-bit cycle counter cnt, compared against parameter-1; all parameters SHALL be >= 2 and < 2^32.
REQ-013 FSM states: IDLE, PRESS_WAIT, HELD, REPEAT, RELEASE_WAIT; all outputs registered.
REQ-014 IDLE: pressed_s=1 -> PRESS_WAIT, cnt=0; otherwise stay, cnt=0.
REQ-015 PRESS_WAIT: pressed_s=0 -> IDLE (bounce rejected, no pulse); cnt==DEBOUNCE_CYCLES-1 -> HELD, cnt=0, level=1, press_pulse=1 next cycle; else cnt+1.
REQ-016 HELD: pressed_s=0 -> RELEASE_WAIT, cnt=0; cnt==HOLD_CYCLES-1 -> REPEAT, cnt=0, repeat_pulse=1; else cnt+1.
REQ-017 REPEAT: pressed_s=0 -> RELEASE_WAIT, cnt=0; cnt==REPEAT_CYCLES-1 -> stay, cnt=0, repeat_pulse=1; else cnt+1.
REQ-018 RELEASE_WAIT: pressed_s=1 -> HELD, cnt=0, no pulse, level stays 1 (release bounce rejected, hold timing restarts); cnt==DEBOUNCE_CYCLES-1 -> IDLE, level=0, release_pulse=1; else cnt+1.
REQ-019 Every pulse output SHALL be high for exactly one cycle; press_pulse, release_pulse and repeat_pulse SHALL never be high in the same cycle.
REQ-020 press_pulse and level rise in the same cycle; release_pulse and level fall in the same cycle.
REQ-021 Latency: with btn_n held low from its first sampling edge (edge 1), press_pulse SHALL be high in the cycle after edge DEBOUNCE_CYCLES+3; release latency symmetric.
REQ-022 First repeat_pulse SHALL occur HOLD_CYCLES cycles after press_pulse; subsequent ones every REPEAT_CYCLES cycles while held.
REQ-023 cnt SHALL never exceed parameter-1 in any state; no wrap-around.

Reset
REQ-024 While rst=1 at a clock edge: state=IDLE, cnt=0, level=0, all pulses 0, both synchronizer flops=1 (released).
REQ-025 Reset mid-operation (any state, button held or not) SHALL take effect at the next edge without emitting any pulse; a still-held button SHALL then be re-debounced from IDLE and produce a fresh press_pulse.
REQ-026 rst SHALL take priority over all FSM transitions.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3)
REQ-027 Clean press: btn_n 1->0 held -> press_pulse high one cycle after edge 7, level=1 from same cycle; no other pulse.
REQ-028 Bounce: btn_n low 3 cycles, high 1, low held -> no pulse during glitch; press_pulse 7 edges after final fall.
REQ-029 Hold/repeat: press held 30 cycles after press_pulse -> repeat_pulse at +10, +13, +16, ... +28 (7 pulses), level stays 1.
REQ-030 Release with bounce: btn_n 0->1 for 2 cycles, 0 for 1, 1 held -> level stays 1 through glitch; release_pulse once, 7 edges after final rise, level=0.
REQ-031 Reset mid-hold: rst=1 for 1 cycle while in REPEAT with btn_n=0 -> level=0, no pulses next cycle; press_pulse again 7 edges after rst deasserts.
REQ-032 Short tap: btn_n low for exactly 3 sampled cycles -> no output activity ever.
